program_run_controller: RTL and testbench
=========================================

// Module: program_run_controller
// PURPOSE
//  Synthesizable run controller for NUM_PROGS program processors (processor_1..N).
//  Runs the processors one after another. For each one it pulses init (cold start) or restart (warm re-run), then waits for done or a timeout.
//  Records the per-program cycle count and timeout status, then raises all_done.
//  Replaces per-program hand-written benches; sits between the top level and the processor_N instances.
// PARAMETERS
//  NUM_PROGS    3      number of processor channels (1..16)
//  PULSE_CYC    1      cycles proc_init/proc_restart are held high (>=1)
//  MAX_CYCLES   4096   watchdog: cycles allowed per program after pulse release
//  CW           16     cycle-counter width; must satisfy 2**CW > MAX_CYCLES
// PORTS
//  clock         in   1             system clock, rising edge
//  init          in   1             synchronous active-high reset
//  start         in   1             one-cycle request to begin a sequence; ignored while busy
//  warm          in   1             sampled with start: 1 = use proc_restart, 0 = use proc_init
//  proc_done     in   NUM_PROGS     level done from each processor
//  proc_init     out  NUM_PROGS     init pulse to each processor
//  proc_restart  out  NUM_PROGS     restart pulse to each processor
//  busy          out  1             sequence in progress
//  all_done      out  1             one-cycle pulse when the sequence completes
//  timeout_flags out  NUM_PROGS     bit i set = program i hit the watchdog (sticky until next start)
//  sel_prog      in   $clog2(N)     index for readback (out-of-range reads 0)
//  sel_cycles    out  CW            cycles program sel_prog took (combinational read of register file)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: proc_init, proc_restart, busy, all_done, timeout_flags. Cycle registers are 0.
//  FSM states: IDLE, PULSE, RUN, ADVANCE, FINISH.
//  IDLE:
//    - start=1 latches warm, sets idx=0, clears timeout_flags and all cycle regs, goes to PULSE.
//    - busy goes high on the next edge.
//  PULSE:
//    - Drives proc_init[idx] (cold) or proc_restart[idx] (warm) high for exactly PULSE_CYC cycles.
//    - All other bits stay 0. Then goes to RUN with cnt=0.
//  RUN:
//    - proc_done[idx] is ignored during PULSE and during the first RUN cycle (processor still settling).
//    - From the second RUN cycle on, each cycle: if proc_done[idx]=1, cycles[idx]<=cnt and go to ADVANCE.
//    - Else if cnt==MAX_CYCLES-1: cycles[idx]<=MAX_CYCLES, timeout_flags[idx]<=1, go to ADVANCE.
//    - Else cnt<=cnt+1.
//    - done and timeout in the same cycle: done wins, no flag.
//  ADVANCE: one cycle.
//    - idx==NUM_PROGS-1 -> FINISH.
//    - Else idx<=idx+1 -> PULSE.
//  FINISH:
//    - all_done=1 for one cycle, busy<=0, then IDLE.
//    - timeout_flags and cycle regs hold until the next start.
//  Latency: start to first pulse edge = 1 cycle.
//    - Done pulse at RUN cycle k (k>=1) gives cycles=k.
//    - Inter-program gap = 1 ADVANCE cycle.
//  Only one channel is ever pulsed. Pulses never overlap between channels.
//  init asserted mid-sequence:
//    - Everything returns to the reset values on that edge.
//    - Any in-flight pulse drops immediately.
//  start while busy: ignored, with no effect on warm or idx.
//  proc_done bits of non-selected channels: ignored.
//  cnt saturates by construction; no wrap because 2**CW > MAX_CYCLES (checked by an elaboration-time $error).
// STRUCTURE
//  Shared package prc_pkg:
//    - typedef enum state_t {IDLE,PULSE,RUN,ADVANCE,FINISH}.
//    - localparam helpers for idx width.
//  One sub-module: prc_watchdog (cnt register, clear/enable/expire, parameters MAX_CYCLES and CW).
//  The FSM, idx, pulse timer and cycle register file stay in the top module.
// TESTING
//  1 Reset: init=1 for 2 cycles -> all outputs 0, busy=0; start held during init is ignored.
//  2 Cold run, N=3, PULSE_CYC=2:
//    - Each proc_done rises 5/7/3 RUN cycles after its pulse ends.
//    - Expect proc_init[0..2] high 2 cycles each, in order.
//    - Expect cycles = 5/7/3, all_done pulse once, timeout_flags=0.
//  3 Warm run, warm=1: only proc_restart bits pulse, proc_init stays 0 throughout.
//  4 Watchdog, MAX_CYCLES=16, program 1 never done:
//    - Expect cycles[1]=16 and timeout_flags=3'b010.
//    - Program 2 still runs; all_done fires.
//  5 Corner cases:
//    - proc_done high during PULSE and in RUN cycle 0 is ignored; a done counted at RUN cycle 1 gives cycles=1.
//    - done on the last watchdog cycle (cnt=15) gives no flag and cycles=15.
//    - start pulsed while busy has no effect.
//  6 init mid-run (during PULSE of program 1):
//    - Pulse drops on the same edge, busy=0.
//    - A new start restarts from program 0.

Source files
------------

// File: rtl/prc_pkg.sv
// rtl/prc_pkg.sv - shared state encoding and width helper for the program run controller
package prc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PULSE   = 3'd1,
    RUN     = 3'd2,
    ADVANCE = 3'd3,
    FINISH  = 3'd4
  } state_t;

  // Width of an index/counter covering 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prc_watchdog.sv
// rtl/prc_watchdog.sv - per-program cycle counter with clear, enable and expiry flag
module prc_watchdog #(
  parameter int MAX_CYCLES = 4096,
  parameter int CW         = 16
) (
  input  logic          clock,
  input  logic          init,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          expire
);

  if (2**CW <= MAX_CYCLES) begin : g_cw_check
    $error("prc_watchdog: CW too narrow, 2**CW must exceed MAX_CYCLES");
  end

  logic [CW-1:0] cnt_q;

  // Counter is cleared while the pulse is applied and advances once per RUN cycle;
  // it stops at MAX_CYCLES-1 because the FSM leaves RUN on expiry.
  always_ff @(posedge clock) begin
    if (init || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cnt    = cnt_q;
  assign expire = (cnt_q == CW'(MAX_CYCLES - 1));

endmodule

// File: rtl/program_run_controller.sv
// rtl/program_run_controller.sv - sequences init/restart pulses over processors and records run lengths
module program_run_controller
  import prc_pkg::*;
#(
  parameter int NUM_PROGS  = 3,
  parameter int PULSE_CYC  = 1,
  parameter int MAX_CYCLES = 4096,
  parameter int CW         = 16
) (
  input  logic                           clock,
  input  logic                           init,
  input  logic                           start,
  input  logic                           warm,
  input  logic [NUM_PROGS-1:0]           proc_done,
  output logic [NUM_PROGS-1:0]           proc_init,
  output logic [NUM_PROGS-1:0]           proc_restart,
  output logic                           busy,
  output logic                           all_done,
  output logic [NUM_PROGS-1:0]           timeout_flags,
  input  logic [idx_w(NUM_PROGS)-1:0]    sel_prog,
  output logic [CW-1:0]                  sel_cycles
);

  localparam int IW = idx_w(NUM_PROGS);
  localparam int PW = idx_w(PULSE_CYC);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic                 warm_q, warm_d;
  logic [NUM_PROGS-1:0] flags_q, flags_d;
  logic [CW-1:0]        cycles_q [NUM_PROGS];
  logic [CW-1:0]        cycles_d [NUM_PROGS];

  logic                 wd_clr, wd_en, wd_expire;
  logic [CW-1:0]        wd_cnt;

  prc_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CW         (CW)
  ) u_watchdog (
    .clock  (clock),
    .init   (init),
    .clr    (wd_clr),
    .en     (wd_en),
    .cnt    (wd_cnt),
    .expire (wd_expire)
  );

  // State, index, pulse timer, flags and cycle register file.
  always_ff @(posedge clock) begin
    if (init) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pcnt_q  <= '0;
      warm_q  <= 1'b0;
      flags_q <= '0;
      for (int i = 0; i < NUM_PROGS; i++) cycles_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pcnt_q   <= pcnt_d;
      warm_q   <= warm_d;
      flags_q  <= flags_d;
      cycles_q <= cycles_d;
    end
  end

  // Next-state logic; done is ignored while cnt is 0 so the processor can settle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pcnt_d   = pcnt_q;
    warm_d   = warm_q;
    flags_d  = flags_q;
    cycles_d = cycles_q;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          warm_d  = warm;
          idx_d   = '0;
          pcnt_d  = '0;
          flags_d = '0;
          for (int i = 0; i < NUM_PROGS; i++) cycles_d[i] = '0;
          state_d = PULSE;
        end
      end
      PULSE: begin
        wd_clr = 1'b1;
        if (pcnt_q == PW'(PULSE_CYC - 1)) begin
          pcnt_d  = '0;
          state_d = RUN;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      RUN: begin
        if ((wd_cnt != '0) && proc_done[idx_q]) begin
          cycles_d[idx_q] = wd_cnt;
          state_d         = ADVANCE;
        end else if (wd_expire) begin
          cycles_d[idx_q] = CW'(MAX_CYCLES);
          flags_d[idx_q]  = 1'b1;
          state_d         = ADVANCE;
        end else begin
          wd_en = 1'b1;
        end
      end
      ADVANCE: begin
        if (idx_q == IW'(NUM_PROGS - 1)) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = PULSE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pulses decode straight from state so a reset edge removes them at once.
  always_comb begin
    proc_init    = '0;
    proc_restart = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      proc_init[i]    = (state_q == PULSE) && !warm_q && (idx_q == IW'(i));
      proc_restart[i] = (state_q == PULSE) &&  warm_q && (idx_q == IW'(i));
    end
  end

  // Readback of the cycle register file; indices past the last channel read 0.
  always_comb begin
    sel_cycles = '0;
    if (int'(sel_prog) < NUM_PROGS) sel_cycles = cycles_q[sel_prog];
  end

  assign busy          = (state_q != IDLE);
  assign all_done      = (state_q == FINISH);
  assign timeout_flags = flags_q;

endmodule

// File: tb/tb_program_run_controller.sv
// tb/tb_program_run_controller.sv - randomized self-checking bench for program_run_controller
module tb_program_run_controller;

  localparam int NP = 3;
  localparam int PC = 2;
  localparam int MX = 16;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          init = 1'b1;
  logic          start = 1'b0;
  logic          warm = 1'b0;
  logic [NP-1:0] proc_done = '0;
  logic [NP-1:0] proc_init, proc_restart, timeout_flags;
  logic          busy, all_done;
  logic [1:0]    sel_prog = '0;
  logic [CW-1:0] sel_cycles;

  int nvec = 0;
  int nerr = 0;

  program_run_controller #(
    .NUM_PROGS (NP), .PULSE_CYC (PC), .MAX_CYCLES (MX), .CW (CW)
  ) dut (
    .clock (clock), .init (init), .start (start), .warm (warm),
    .proc_done (proc_done), .proc_init (proc_init), .proc_restart (proc_restart),
    .busy (busy), .all_done (all_done), .timeout_flags (timeout_flags),
    .sel_prog (sel_prog), .sel_cycles (sel_cycles)
  );

  always #5 clock = ~clock;

  // Reference: a processor whose done rises at RUN cycle lat.
  function automatic int exp_cycles(input int lat);
    if (lat == 0) return 1;
    if (lat <= MX - 1) return lat;
    return MX;
  endfunction

  task automatic test_reset();
    init = 1'b1; start = 1'b1; warm = 1'b0;
    @(negedge clock); @(negedge clock);
    #1;
    nvec++; if ({proc_init, proc_restart, busy, all_done, timeout_flags} !== '0) begin
      nerr++; $display("FAIL reset_outputs: got %0h want 0", {proc_init, proc_restart, busy, all_done, timeout_flags});
    end
    for (int i = 0; i < NP; i++) begin
      sel_prog = 2'(i); #1;
      nvec++; if (sel_cycles !== '0) begin
        nerr++; $display("FAIL reset_cycles[%0d]: got %0d want 0", i, sel_cycles);
      end
    end
    @(negedge clock); init = 1'b0; start = 1'b0;
    @(negedge clock); #1;
    nvec++; if (busy !== 1'b0 || proc_init !== '0) begin
      nerr++; $display("FAIL reset_start_ignored: got busy=%0b init=%0h want 0 0", busy, proc_init);
    end
  endtask

  task automatic run_seq(input bit w, input int l0, input int l1, input int l2, input bit poke);
    int lat[NP];
    int cur, width, r, nstart;
    bit in_run, fin;
    logic [NP-1:0] pulse, other, ef;
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
    @(negedge clock); proc_done = '0; warm = w; start = 1'b1;
    @(negedge clock); start = 1'b0; warm = ~w; sel_prog = 2'd0; #1;
    nvec++; if (busy !== 1'b1 || timeout_flags !== '0 || sel_cycles !== '0) begin
      nerr++; $display("FAIL start_clears: got busy=%0b flags=%0h cyc0=%0d want 1 0 0", busy, timeout_flags, sel_cycles);
    end
    cur = -1; width = 0; r = 0; nstart = 0; in_run = 0; fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (c > 0) begin @(negedge clock); #1; end
      start = (poke && c == 9);
      warm  = $urandom_range(0, 1);
      pulse = w ? proc_restart : proc_init;
      other = w ? proc_init : proc_restart;
      nvec++; if (other !== '0 || busy !== 1'b1) begin
        nerr++; $display("FAIL pulse_kind_busy c=%0d: got other=%0h busy=%0b want 0 1", c, other, busy);
      end
      if (pulse !== '0) begin
        if (width == 0) begin cur++; nstart++; in_run = 0; end
        width++;
        nvec++; if (cur > NP - 1 || pulse !== NP'(1 << cur)) begin
          nerr++; $display("FAIL pulse_onehot: got %0h want channel %0d", pulse, cur);
        end
        if (cur <= NP - 1 && lat[cur] == 0) proc_done[cur] = 1'b1;
      end else begin
        if (width > 0) begin
          nvec++; if (width != PC) begin
            nerr++; $display("FAIL pulse_width ch%0d: got %0d want %0d", cur, width, PC);
          end
          width = 0; in_run = 1; r = 0;
        end else if (in_run) begin
          r++;
        end
        if (in_run && cur >= 0 && cur <= NP - 1 && r == lat[cur]) proc_done[cur] = 1'b1;
      end
      if (all_done === 1'b1) fin = 1;
    end
    start = 1'b0;
    nvec++; if (!fin || nstart != NP) begin
      nerr++; $display("FAIL seq_complete: got done=%0b pulses=%0d want 1 %0d", fin, nstart, NP);
    end
    @(negedge clock); #1;
    nvec++; if (busy !== 1'b0 || all_done !== 1'b0) begin
      nerr++; $display("FAIL finish_one_cycle: got busy=%0b all_done=%0b want 0 0", busy, all_done);
    end
    for (int i = 0; i < NP; i++) ef[i] = (lat[i] >= MX);
    nvec++; if (timeout_flags !== ef) begin
      nerr++; $display("FAIL timeout_flags: got %03b want %03b", timeout_flags, ef);
    end
    for (int i = 0; i < NP; i++) begin
      sel_prog = 2'(i); #1;
      nvec++; if (sel_cycles !== CW'(exp_cycles(lat[i]))) begin
        nerr++; $display("FAIL cycles[%0d]: got %0d want %0d", i, sel_cycles, exp_cycles(lat[i]));
      end
    end
    sel_prog = 2'd3; #1;
    nvec++; if (sel_cycles !== '0) begin
      nerr++; $display("FAIL sel_out_of_range: got %0d want 0", sel_cycles);
    end
  endtask

  task automatic test_cold();     run_seq(1'b0, 5, 7, 3, 1'b0);   endtask
  task automatic test_warm();     run_seq(1'b1, 5, 7, 3, 1'b0);   endtask
  task automatic test_watchdog(); run_seq(1'b0, 5, 99, 4, 1'b0);  endtask

  task automatic test_corner();
    run_seq(1'b0, 0, 15, 16, 1'b1);
    run_seq(1'b1, 1, 14, 0, 1'b1);
  endtask

  task automatic test_init_mid_run();
    bit hit;
    hit = 0;
    @(negedge clock); proc_done = 3'b001; warm = 1'b0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      #1;
      if (proc_init[1] === 1'b1) begin init = 1'b1; hit = 1; end
      else @(negedge clock);
    end
    nvec++; if (!hit) begin
      nerr++; $display("FAIL mid_run_reach_prog1: got no pulse want pulse on ch1");
    end
    @(negedge clock); sel_prog = 2'd0; #1;
    nvec++; if (proc_init !== '0 || proc_restart !== '0 || busy !== 1'b0 || timeout_flags !== '0 || sel_cycles !== '0) begin
      nerr++; $display("FAIL mid_run_init: got init=%0h rst=%0h busy=%0b flags=%0h cyc0=%0d want all 0",
                       proc_init, proc_restart, busy, timeout_flags, sel_cycles);
    end
    init = 1'b0;
    run_seq(1'b0, 4, 2, 6, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_seq(1'($urandom_range(0, 1)), $urandom_range(0, 18), $urandom_range(0, 18),
              $urandom_range(0, 18), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_cold();
    test_warm();
    test_watchdog();
    test_corner();
    test_init_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
